// File: rtl/snake_pkg.sv
// Shared encodings for the snake move scheduler: game status, directions
// and the scheduler state enum.
package snake_pkg;

    localparam logic [2:0] GS_START = 3'b001;
    localparam logic [2:0] GS_PLAY  = 3'b010;
    localparam logic [2:0] GS_END   = 3'b100;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_MOVE      = 2'd2
    } sched_state_e;

    // Up/down and left/right differ only in bit 0.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_move_scheduler_if.sv
// Bundle between the scheduler, the game-status controller, the keys and
// the body/collision datapath.
interface snake_move_scheduler_if #(
    parameter int LEN_W = 5
);
    import snake_pkg::*;

    logic [2:0]       Game_status;
    logic             Key_left;
    logic             Key_right;
    logic             Key_up;
    logic             Key_down;
    logic             Food_eaten;
    logic             Move_ack;
    logic             Move_req;
    logic             Grow;
    logic [1:0]       Dir;
    logic [LEN_W-1:0] Body_len;
    logic [2:0]       Speed_level;
    sched_state_e     State_dbg;

    // Move_req is held high (with Dir and Grow stable) until Move_ack is seen
    // high on a rising edge; a step completes on exactly that edge, and
    // Move_ack may arrive in the first Move_req cycle.
    modport slave (
        input  Game_status, Key_left, Key_right, Key_up, Key_down,
        input  Food_eaten, Move_ack,
        output Move_req, Grow, Dir, Body_len, Speed_level, State_dbg
    );

    modport master (
        output Game_status, Key_left, Key_right, Key_up, Key_down,
        output Food_eaten, Move_ack,
        input  Move_req, Grow, Dir, Body_len, Speed_level, State_dbg
    );

endinterface

// File: rtl/snake_tick_divider.sv
// Programmable-period counter: counts while not cleared and pulses tick_o
// on the cycle the count equals period_i-1, then wraps to zero.
module snake_tick_divider #(
    parameter int CNT_W = 22
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = !clr_i && (cnt_q == period_i - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_move_scheduler.sv
// Paces snake steps during PLAY, commits direction without reversals, and
// tracks pending growth and speed level from food events.
module snake_move_scheduler
    import snake_pkg::*;
#(
    parameter int TICK_DIV     = 2_400_000,
    parameter int MIN_DIV      = 600_000,
    parameter int SPEEDUP_STEP = 120_000,
    parameter int MAX_LEN      = 16,
    parameter int INIT_LEN     = 3,
    parameter int LEN_W        = 5
) (
    input logic                   Clk_24mhz,
    input logic                   Rst,
    snake_move_scheduler_if.slave bus
);

    localparam int CNT_W  = $clog2(TICK_DIV + 1);
    localparam int PROD_W = CNT_W + 3;
    localparam logic [PROD_W-1:0] TICK_P = PROD_W'(TICK_DIV);
    localparam logic [PROD_W-1:0] MIN_P  = PROD_W'(MIN_DIV);
    localparam logic [PROD_W-1:0] STEP_P = PROD_W'(SPEEDUP_STEP);

    sched_state_e     state_q, state_d;
    logic [1:0]       dir_q, dir_d, dir_next_q, dir_next_d;
    logic             grow_q, grow_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       speed_q, speed_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       food_q, food_d;
    logic [CNT_W-1:0] period_q, period_d, period_calc;
    logic [PROD_W-1:0] reduction;

    logic is_play, is_start, ack_ok, rise, enter_wait, tick;
    logic key_valid, grow_dec;
    logic [1:0] key_dir;

    snake_tick_divider #(.CNT_W(CNT_W)) u_tick (
        .clk_i   (Clk_24mhz),
        .rst_i   (Rst),
        .clr_i   (state_q != ST_WAIT_TICK),
        .period_i(period_q),
        .tick_o  (tick)
    );

    // Compare before subtracting so the period never underflows.
    always_comb begin
        reduction = PROD_W'(speed_q) * STEP_P;
        if (reduction + MIN_P >= TICK_P) begin
            period_calc = CNT_W'(MIN_DIV);
        end else begin
            period_calc = CNT_W'(TICK_P - reduction);
        end
    end

    always_comb begin
        is_play  = (bus.Game_status == GS_PLAY);
        is_start = (bus.Game_status == GS_START);
        ack_ok   = (state_q == ST_MOVE) && is_play && bus.Move_ack;

        state_d = state_q;
        if (!is_play) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_TICK;
                ST_WAIT_TICK: if (tick) state_d = ST_MOVE;
                ST_MOVE:      if (bus.Move_ack) state_d = ST_WAIT_TICK;
                default:      state_d = ST_IDLE;
            endcase
        end
        rise       = (state_q == ST_WAIT_TICK) && (state_d == ST_MOVE);
        enter_wait = (state_d == ST_WAIT_TICK) && (state_q != ST_WAIT_TICK);
    end

    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_RIGHT;
        if (bus.Key_up)         key_dir = DIR_UP;
        else if (bus.Key_down)  key_dir = DIR_DOWN;
        else if (bus.Key_left)  key_dir = DIR_LEFT;
        else if (bus.Key_right) key_dir = DIR_RIGHT;
        else                    key_valid = 1'b0;
    end

    always_comb begin
        dir_d      = dir_q;
        dir_next_d = dir_next_q;
        grow_d     = grow_q;
        len_d      = len_q;
        speed_d    = speed_q;
        pend_d     = pend_q;
        food_d     = food_q;
        grow_dec   = ack_ok && grow_q;
        period_d   = enter_wait ? period_calc : period_q;

        if (is_start) begin
            dir_d      = DIR_RIGHT;
            dir_next_d = DIR_RIGHT;
            len_d      = LEN_W'(INIT_LEN);
            speed_d    = '0;
            pend_d     = '0;
            food_d     = '0;
        end else if (is_play) begin
            // Reversal is judged against the committed direction only.
            if (key_valid && (key_dir != dir_opposite(dir_q))) begin
                dir_next_d = key_dir;
            end
            if (rise) begin
                dir_d  = dir_next_q;
                grow_d = (pend_q != 2'd0) && (len_q < LEN_W'(MAX_LEN));
            end
            if (grow_dec) begin
                len_d = len_q + LEN_W'(1);
            end
            if (len_q == LEN_W'(MAX_LEN)) begin
                pend_d = '0;
            end else if (bus.Food_eaten && !grow_dec) begin
                pend_d = (pend_q == 2'd3) ? 2'd3 : pend_q + 2'd1;
            end else if (!bus.Food_eaten && grow_dec) begin
                pend_d = pend_q - 2'd1;
            end
            if (bus.Food_eaten) begin
                food_d = food_q + 2'd1;
                if ((food_q == 2'd3) && (speed_q != 3'd7)) begin
                    speed_d = speed_q + 3'd1;
                end
            end
        end

        if (state_d != ST_MOVE) begin
            grow_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_24mhz or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_RIGHT;
            dir_next_q <= DIR_RIGHT;
            grow_q     <= 1'b0;
            len_q      <= LEN_W'(INIT_LEN);
            speed_q    <= '0;
            pend_q     <= '0;
            food_q     <= '0;
            period_q   <= CNT_W'(TICK_DIV);
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            dir_next_q <= dir_next_d;
            grow_q     <= grow_d;
            len_q      <= len_d;
            speed_q    <= speed_d;
            pend_q     <= pend_d;
            food_q     <= food_d;
            period_q   <= period_d;
        end
    end

    assign bus.Move_req    = (state_q == ST_MOVE);
    assign bus.Grow        = grow_q;
    assign bus.Dir         = dir_q;
    assign bus.Body_len    = len_q;
    assign bus.Speed_level = speed_q;
    assign bus.State_dbg   = state_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Bench for snake_move_scheduler: directed scenarios pinned by literals plus
// random stimulus checked every cycle against a step-level behavioural model.
module tb_snake_move_scheduler;
    import snake_pkg::*;

    localparam int TICK_DIV = 10, MIN_DIV = 4, SPEEDUP_STEP = 2;
    localparam int MAX_LEN = 5, INIT_LEN = 3, LEN_W = 5;
    localparam int EW = 2 + 2 + LEN_W + 3 + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    snake_move_scheduler_if #(.LEN_W(LEN_W)) bus ();

    snake_move_scheduler #(
        .TICK_DIV(TICK_DIV), .MIN_DIV(MIN_DIV), .SPEEDUP_STEP(SPEEDUP_STEP),
        .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .LEN_W(LEN_W)
    ) dut (
        .Clk_24mhz(clk),
        .Rst      (rst),
        .bus      (bus)
    );

    int n_vec = 0, n_err = 0;
    int cyc = 0, n_rise = 0, last_rise = 0, prev_rise = 0, play_ref = 0;
    bit prev_req = 0, auto_ack = 1;
    int ack_lat = 2, ack_age = 0;
    logic [EW-1:0] exp_q[$];

    // Behavioural model: "moving" means a request is outstanding, "waiting"
    // means the move timer is running with m_cnt cycles already elapsed.
    bit m_req, m_wait, m_grow;
    int m_cnt, m_period, m_dir, m_dnext, m_len, m_lvl, m_pend, m_food;

    function automatic int calc_period(input int lvl);
        int p;
        p = TICK_DIV - lvl * SPEEDUP_STEP;
        return (p < MIN_DIV) ? MIN_DIV : p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_wait = 0; m_grow = 0; m_cnt = 0; m_period = TICK_DIV;
        m_dir = 3; m_dnext = 3; m_len = INIT_LEN; m_lvl = 0; m_pend = 0; m_food = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit play, ackd, rise, n_req, n_wait, n_grow;
        int k, n_cnt, n_period, n_dir, n_dnext, n_len, n_lvl, n_pend, n_food;
        logic [1:0] st;
        play = (bus.Game_status == GS_PLAY);
        n_req = m_req; n_wait = m_wait; n_grow = m_grow; n_cnt = m_cnt;
        n_period = m_period; n_dir = m_dir; n_dnext = m_dnext; n_len = m_len;
        n_lvl = m_lvl; n_pend = m_pend; n_food = m_food;
        if (bus.Game_status == GS_START) begin
            n_len = INIT_LEN; n_dir = 3; n_dnext = 3; n_lvl = 0; n_pend = 0; n_food = 0;
        end
        if (!play) begin
            n_req = 0; n_wait = 0; n_grow = 0;
        end else begin
            k = bus.Key_up ? 0 : bus.Key_down ? 1 : bus.Key_left ? 2 : bus.Key_right ? 3 : -1;
            if (k >= 0 && k != (m_dir ^ 1)) n_dnext = k;
            ackd = m_req && bus.Move_ack;
            rise = m_wait && (m_cnt == m_period - 1);
            if (!m_req && !m_wait) begin
                n_wait = 1; n_cnt = 0; n_period = calc_period(m_lvl);
            end else if (ackd) begin
                n_req = 0; n_wait = 1; n_cnt = 0; n_period = calc_period(m_lvl);
                n_grow = 0;
                if (m_grow) n_len = m_len + 1;
            end else if (rise) begin
                n_req = 1; n_wait = 0; n_dir = m_dnext;
                n_grow = (m_pend != 0) && (m_len < MAX_LEN);
            end else if (m_wait) begin
                n_cnt = m_cnt + 1;
            end
            if (m_len == MAX_LEN) n_pend = 0;
            else if (bus.Food_eaten && !(ackd && m_grow)) n_pend = (m_pend == 3) ? 3 : m_pend + 1;
            else if (!bus.Food_eaten && ackd && m_grow) n_pend = m_pend - 1;
            if (bus.Food_eaten) begin
                if (m_food == 3 && m_lvl < 7) n_lvl = m_lvl + 1;
                n_food = (m_food + 1) % 4;
            end
        end
        m_req = n_req; m_wait = n_wait; m_grow = n_grow; m_cnt = n_cnt;
        m_period = n_period; m_dir = n_dir; m_dnext = n_dnext; m_len = n_len;
        m_lvl = n_lvl; m_pend = n_pend; m_food = n_food;
        st = m_req ? 2'(ST_MOVE) : (m_wait ? 2'(ST_WAIT_TICK) : 2'(ST_IDLE));
        exp_q.push_back({m_req, m_grow, 2'(m_dir), LEN_W'(m_len), 3'(m_lvl), st});
    endtask

    task automatic compare();
        logic [EW-1:0] e;
        check("scoreboard_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("Move_req", bus.Move_req, e[EW-1]);
            check("Grow", bus.Grow, e[EW-2]);
            check("Dir", bus.Dir, e[EW-3 -: 2]);
            check("Body_len", bus.Body_len, e[LEN_W+4 : 5]);
            check("Speed_level", bus.Speed_level, e[4:2]);
            check("State_dbg", bus.State_dbg, e[1:0]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare();
        if (bus.Move_req && !prev_req) begin
            prev_rise = last_rise; last_rise = cyc; n_rise++;
        end
        prev_req = bus.Move_req;
        bus.Key_up = 0; bus.Key_down = 0; bus.Key_left = 0; bus.Key_right = 0;
        bus.Food_eaten = 0;
        bus.Move_ack = 0;
        if (m_req) begin
            if (auto_ack) bus.Move_ack = (ack_age == ack_lat);
            ack_age++;
        end else begin
            ack_age = 0;
        end
    endtask

    task automatic wait_rise();
        int start;
        start = n_rise;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (n_rise != start) break;
        end
        check("rise_seen", n_rise - start, 1);
    endtask

    task automatic wait_req_low();
        for (int i = 0; i < 50; i++) begin
            if (!bus.Move_req) break;
            cycle();
        end
        check("req_drop", bus.Move_req, 0);
    endtask

    task automatic food_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Food_eaten = 1;
            cycle();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, bus.Move_req, 0);
        check({tag, "_grow"}, bus.Grow, 0);
        check({tag, "_dir"}, bus.Dir, 3);
        check({tag, "_len"}, bus.Body_len, INIT_LEN);
        check({tag, "_speed"}, bus.Speed_level, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1;
        model_reset();
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst = 0; prev_req = 0; ack_age = 0; bus.Move_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int len_before, r, s;
        bus.Game_status = GS_START;
        bus.Key_up = 0; bus.Key_down = 0; bus.Key_left = 0; bus.Key_right = 0;
        bus.Food_eaten = 0; bus.Move_ack = 0;
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        check("reset_state", bus.State_dbg, ST_IDLE);
        rst = 0;

        // First step timing and steady spacing
        bus.Game_status = GS_PLAY; play_ref = cyc;
        wait_rise();
        check("first_req_delay", last_rise - play_ref, 11);
        check("first_dir", bus.Dir, 3);
        check("first_grow", bus.Grow, 0);
        check("first_len", bus.Body_len, 3);
        wait_rise();
        check("step_spacing", last_rise - prev_rise, 13);

        // Up then left in one period: left reverses committed right, so up wins
        bus.Key_up = 1; cycle();
        bus.Key_left = 1; wait_rise();
        check("dir_up_left", bus.Dir, 0);
        bus.Key_left = 1; wait_rise();
        check("dir_left", bus.Dir, 2);
        bus.Key_right = 1; wait_rise();
        check("dir_right_discarded", bus.Dir, 2);

        // Growth up to MAX_LEN
        food_pulses(3);
        wait_rise(); check("grow_1", bus.Grow, 1);
        wait_req_low(); check("len_4", bus.Body_len, 4);
        wait_rise(); check("grow_2", bus.Grow, 1);
        wait_req_low(); check("len_5", bus.Body_len, 5);
        wait_rise(); check("grow_at_max", bus.Grow, 0);
        wait_req_low(); check("len_max_hold", bus.Body_len, 5);

        // Speed levels and resulting period
        bus.Game_status = GS_START; cycle(); cycle();
        bus.Game_status = GS_PLAY;
        food_pulses(8);
        check("speed_2", bus.Speed_level, 2);
        wait_rise(); wait_rise();
        check("spacing_lvl2", last_rise - prev_rise, 9);
        food_pulses(16);
        check("speed_6", bus.Speed_level, 6);
        wait_rise(); wait_rise();
        check("spacing_lvl6", last_rise - prev_rise, 7);

        // END during MOVE: acks are ignored, nothing updates
        wait_rise();
        auto_ack = 0;
        len_before = m_len;
        bus.Game_status = GS_END; bus.Move_ack = 1;
        cycle();
        check("end_req_low", bus.Move_req, 0);
        bus.Move_ack = 1;
        cycle();
        check("end_len_hold", bus.Body_len, len_before);
        check("end_speed_hold", bus.Speed_level, 6);
        bus.Game_status = GS_START; cycle();
        check("start_len", bus.Body_len, 3);
        check("start_dir", bus.Dir, 3);
        check("start_speed", bus.Speed_level, 0);
        auto_ack = 1;

        // Non-reset values, then async reset in the middle of MOVE
        bus.Game_status = GS_PLAY;
        bus.Key_up = 1; cycle();
        food_pulses(5);
        wait_rise();
        check("pre_reset_dir", bus.Dir, 0);
        check("pre_reset_grow", bus.Grow, 1);
        check("pre_reset_speed", bus.Speed_level, 1);
        do_reset();
        play_ref = cyc;
        wait_rise();
        check("post_reset_delay", last_rise - play_ref, 11);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                s = $urandom_range(0, 9);
                bus.Game_status = (s == 0) ? GS_START : (s < 3) ? GS_END : GS_PLAY;
            end else if (r < 8) begin
                bus.Game_status = GS_PLAY;
            end
            bus.Key_up    = ($urandom_range(0, 9) == 0);
            bus.Key_down  = ($urandom_range(0, 9) == 0);
            bus.Key_left  = ($urandom_range(0, 9) == 0);
            bus.Key_right = ($urandom_range(0, 9) == 0);
            bus.Food_eaten = ($urandom_range(0, 5) == 0);
            if (!m_req) ack_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
